// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int                DEFAULT_XLEN     = 32;
    localparam logic [31:0]       DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int                INSTR_BYTES      = 4;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0]             instr;
        logic [DEFAULT_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush input. Storage is registered and the
// head entry is read straight out of the storage flops, so a push into an
// empty FIFO becomes visible on the following cycle.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Next-state for pointers, occupancy and storage; flush overrides all.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && (count_q != CNT_MAX);
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {{(CW-1){1'b0}}, do_push_s}
                              - {{(CW-1){1'b0}}, do_pop_s};
        end
    end

    // State registers; storage clears on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit_chk.sv
// Invariant checks for the fetch unit's credit and discard bookkeeping.
module fetch_unit_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] discard,
    input logic [CW-1:0] shadow_count,
    input logic [CW-1:0] fifo_count
);

    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // Outstanding reads plus buffered entries never exceed the buffer size.
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, outstanding} + {1'b0, fifo_count}) <= DEPTH_C));

    // Only reads that are actually in flight can be marked for discard.
    a_discard: assert property (@(posedge clk) disable iff (!rst_n)
        (discard <= outstanding));

    // Every kept in-flight read has exactly one tag PC waiting for it.
    a_shadow: assert property (@(posedge clk) disable iff (!rst_n)
        (shadow_count == (outstanding - discard)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// response buffering and redirect flush.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect
// raises a sticky fetch_err and halts fetch).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_err
);

    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam int              EW       = $bits(fetch_entry_t);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW:0]     DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW:0]     credit_sum_s;
    logic            halted_s;
    logic            req_fire_s;
    logic            rsp_keep_s;
    logic            instr_pop_s;
    logic [XLEN-1:0] target_s;

    fetch_entry_t    ififo_wdata_s;
    logic [EW-1:0]   ififo_rdata_s;
    fetch_entry_t    ififo_head_s;
    logic [CW-1:0]   ififo_count_s;
    logic [XLEN-1:0] shadow_pc_s;
    logic [CW-1:0]   shadow_count_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q, err_d;
    logic misalign_s;

    // Misaligned redirect target is kept as-is and flagged.
    always_comb begin
        target_s   = redirect_pc;
        misalign_s = (redirect_pc[1:0] != 2'b00);
        err_d      = err_q | (redirect_valid & misalign_s);
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign halted_s  = err_q;
    assign fetch_err = err_q;
`else
    // Redirect target is forced word-aligned.
    always_comb begin
        target_s = redirect_pc & ALIGN_MASK;
    end

    assign halted_s  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Request credit, handshake qualification and buffer control.
    always_comb begin
        credit_sum_s   = {1'b0, outstanding_q} + {1'b0, ififo_count_s};
        imem_req_valid = rst_n && !halted_s && !redirect_valid
                         && (credit_sum_s < DEPTH_C);
        req_fire_s     = imem_req_valid && imem_req_ready;
        rsp_keep_s     = imem_rsp_valid && !redirect_valid
                         && (discard_q == {CW{1'b0}});
        instr_pop_s    = instr_valid && instr_ready && !redirect_valid;
        ififo_wdata_s.instr = imem_rsp_data;
        ififo_wdata_s.pc    = shadow_pc_s;
    end

    // Next PC, in-flight count and discard count; redirect wins.
    always_comb begin
        pc_d          = pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + {{(CW-1){1'b0}}, req_fire_s}
                                      - {{(CW-1){1'b0}}, imem_rsp_valid};
        if (redirect_valid) begin
            pc_d      = target_s;
            discard_d = outstanding_d;
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + PC_STEP;
            end else begin
                pc_d = pc_q;
            end
            if (imem_rsp_valid && (discard_q != {CW{1'b0}})) begin
                discard_d = discard_q - CNT_ONE;
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            discard_q     <= {CW{1'b0}};
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Tag PCs of kept in-flight reads, matched to responses in order.
    fetch_fifo #(
        .W     (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (req_fire_s),
        .wdata (pc_q),
        .pop   (rsp_keep_s),
        .rdata (shadow_pc_s),
        .count (shadow_count_s)
    );

    // Instruction buffer feeding the decoder.
    fetch_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_ififo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (rsp_keep_s),
        .wdata (ififo_wdata_s),
        .pop   (instr_pop_s),
        .rdata (ififo_rdata_s),
        .count (ififo_count_s)
    );

    assign ififo_head_s  = fetch_entry_t'(ififo_rdata_s);
    assign instr_valid   = (ififo_count_s != {CW{1'b0}});
    assign instr         = ififo_head_s.instr;
    assign instr_pc      = ififo_head_s.pc;
    assign imem_req_addr = pc_q;

    fetch_unit_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .outstanding  (outstanding_q),
        .discard      (discard_q),
        .shadow_count (shadow_count_s),
        .fifo_count   (ififo_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. Memory model: in-order queue
// of accepted addresses; each cycle with rsp enabled returns the oldest
// address accepted in an earlier cycle, data = ~address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] mq [$];

    typedef struct {
        bit          rst;
        bit          ir;
        bit          qr;
        bit          re;
        bit          rd;
        logic [31:0] rpc;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_ipc;
        bit          e_err;
    } vec_t;

    vec_t vecs [$];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit ir, input bit qr, input bit re,
                       input bit rd, input logic [31:0] rpc, input bit e_rv,
                       input logic [31:0] e_addr, input bit e_iv,
                       input logic [31:0] e_ipc, input bit e_err);
        vec_t v;
        v.rst = rst; v.ir = ir; v.qr = qr; v.re = re; v.rd = rd; v.rpc = rpc;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
        v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        mq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit ir, input bit qr, input bit re, input bit rd,
                         input logic [31:0] rpc);
        instr_ready = ir;
        imem_req_ready = qr;
        redirect_valid = rd;
        redirect_pc = rpc;
        if (re && (mq.size() > 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = ~mq[0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = 32'h0;
        end
    endtask

    task automatic advance();
        bit          hs;
        bit          took;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        took = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (took) void'(mq.pop_front());
        if (hs) mq.push_back(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        int          pops;
        vec_t        v;

        // A: free-running memory, 1-cycle response
        add(1,1,1,1,0,32'h0, 1,32'h0,  0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 1,32'h4,  0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 0,32'h8,  1,32'h0, 0);
        add(0,1,1,1,0,32'h0, 1,32'h8,  1,32'h4, 0);
        add(0,1,1,1,0,32'h0, 1,32'hC,  0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 0,32'h10, 1,32'h8, 0);
        add(0,1,1,1,0,32'h0, 1,32'h10, 1,32'hC, 0);
        // B: decoder stalled 10 cycles, credits run out after 2 requests
        add(1,0,1,1,0,32'h0, 1,32'h0,  0,32'h0, 0);
        add(0,0,1,1,0,32'h0, 1,32'h4,  0,32'h0, 0);
        for (int i = 0; i < 8; i++) add(0,0,1,1,0,32'h0, 0,32'h8, 1,32'h0, 0);
        add(0,1,1,1,0,32'h0, 0,32'h8,  1,32'h0, 0);
        add(0,1,1,1,0,32'h0, 1,32'h8,  1,32'h4, 0);
        add(0,1,1,1,0,32'h0, 1,32'hC,  0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 0,32'h10, 1,32'h8, 0);
        // C: redirect with two reads in flight
        add(1,1,1,0,0,32'h0,   1,32'h0,   0,32'h0,   0);
        add(0,1,1,0,0,32'h0,   1,32'h4,   0,32'h0,   0);
        add(0,1,1,0,1,32'h100, 0,32'h8,   0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   0,32'h100, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   1,32'h100, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   1,32'h104, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   0,32'h108, 1,32'h100, 0);
        add(0,1,1,1,0,32'h0,   1,32'h108, 1,32'h104, 0);
        // D: redirect coincides with a response, 0x10 still in flight
        add(1,1,1,1,0,32'h0,   1,32'h0,   0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   1,32'h4,   0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   0,32'h8,   1,32'h0,   0);
        add(0,1,1,1,0,32'h0,   1,32'h8,   1,32'h4,   0);
        add(0,1,1,1,0,32'h0,   1,32'hC,   0,32'h0,   0);
        add(0,1,1,0,0,32'h0,   0,32'h10,  1,32'h8,   0);
        add(0,1,1,0,0,32'h0,   1,32'h10,  0,32'h0,   0);
        add(0,1,1,1,1,32'h200, 0,32'h14,  0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   1,32'h200, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   1,32'h204, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0,   0,32'h208, 1,32'h200, 0);
        // E: memory not ready for 5 cycles, address holds
        add(1,1,0,1,0,32'h0, 1,32'h0, 0,32'h0, 0);
        for (int i = 0; i < 4; i++) add(0,1,0,1,0,32'h0, 1,32'h0, 0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 1,32'h0, 0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 1,32'h4, 0,32'h0, 0);
        add(0,1,1,1,0,32'h0, 0,32'h8, 1,32'h0, 0);
        // F: misaligned redirect
        add(1,1,1,1,0,32'h0,   1,32'h0, 0,32'h0, 0);
        add(0,1,1,1,1,32'h102, 0,32'h4, 0,32'h0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        add(0,1,1,1,0,32'h0, 0,32'h102, 0,32'h0, 1);
        add(0,1,1,1,0,32'h0, 0,32'h102, 0,32'h0, 1);
        add(0,1,1,1,0,32'h0, 0,32'h102, 0,32'h0, 1);
`else
        add(0,1,1,1,0,32'h0, 1,32'h100, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0, 1,32'h104, 0,32'h0,   0);
        add(0,1,1,1,0,32'h0, 0,32'h108, 1,32'h100, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) reset_dut();
            drive(v.ir, v.qr, v.re, v.rd, v.rpc);
            #2;
            check($sformatf("row%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, v.e_rv});
            check($sformatf("row%0d_req_addr", i), imem_req_addr, v.e_addr);
            check($sformatf("row%0d_instr_valid", i), {31'h0, instr_valid}, {31'h0, v.e_iv});
            check($sformatf("row%0d_fetch_err", i), {31'h0, fetch_err}, {31'h0, v.e_err});
            if (v.e_iv) begin
                check($sformatf("row%0d_instr_pc", i), instr_pc, v.e_ipc);
                check($sformatf("row%0d_instr", i), instr, ~v.e_ipc);
            end
            advance();
        end

        // Mixed backpressure run with one redirect, scoreboarded by PC order
        reset_dut();
        exp_pc = 32'h0;
        pops = 0;
        for (int c = 0; c < 80; c++) begin
            bit rd;
            rd = (c == 40);
            drive((c % 3) != 0, (c % 5) != 0, (c % 4) != 0, rd, 32'h400);
            #2;
            if (instr_valid && instr_ready && !rd) begin
                check($sformatf("soak%0d_pc", c), instr_pc, exp_pc);
                check($sformatf("soak%0d_instr", c), instr, ~exp_pc);
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            if (rd) exp_pc = 32'h400;
            advance();
        end
        check("soak_progress", {31'h0, (pops >= 10)}, 32'h1);
        check("soak_reached_target", {31'h0, (exp_pc > 32'h400)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
